// File: rtl/line_fifo_640x16.sv
// Single-clock line FIFO (640 x 16) with registered read data, fill count and guarded full/empty.
// Optional show-ahead read port: define LINE_FIFO_SHOWAHEAD_EN.
module line_fifo_640x16 #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 640,
    parameter int USEDW_WIDTH = 10
) (
    input  logic                   clock,
    input  logic                   sclr,
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic                   wrreq,
    input  logic                   rdreq,
    output logic [DATA_WIDTH-1:0]  q,
    output logic [USEDW_WIDTH-1:0] usedw,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [USEDW_WIDTH-1:0] FULL_CNT = USEDW_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [USEDW_WIDTH-1:0] cnt, cnt_next;
    logic                   wr_ok, rd_ok;
    logic [DATA_WIDTH-1:0]  q_reg;

    // A full FIFO still takes a write when the same cycle pops the head.
    assign wr_ok = wrreq && (!full || rdreq);
    assign rd_ok = rdreq && !empty;

    always_comb begin
        cnt_next = cnt;
        case ({wr_ok, rd_ok})
            2'b10:   cnt_next = cnt + 1'b1;
            2'b01:   cnt_next = cnt - 1'b1;
            default: cnt_next = cnt;
        endcase
    end

    // Memory is never cleared; a reset only forgets what it holds.
    always_ff @(posedge clock) begin
        if (wr_ok && !sclr)
            mem[wr_ptr] <= data;
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_ok)
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            if (rd_ok)
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            cnt   <= cnt_next;
            full  <= (cnt_next == FULL_CNT);
            empty <= (cnt_next == '0);
        end
    end

`ifdef LINE_FIFO_SHOWAHEAD_EN
    // Head word is presented directly; q_reg remembers it for when the FIFO drains.
    always_ff @(posedge clock) begin
        if (sclr)
            q_reg <= '0;
        else if (!empty)
            q_reg <= mem[rd_ptr];
    end

    assign q = empty ? q_reg : mem[rd_ptr];
`else
    always_ff @(posedge clock) begin
        if (sclr)
            q_reg <= '0;
        else if (rd_ok)
            q_reg <= mem[rd_ptr];
    end

    assign q = q_reg;
`endif

    assign usedw = cnt;
endmodule

// File: tb/tb_line_fifo_640x16.sv
// Directed bench for line_fifo_640x16 in default (registered read) mode.
module tb_line_fifo_640x16;
    logic        clock = 1'b0;
    logic        sclr, wrreq, rdreq;
    logic [15:0] data, q;
    logic [9:0]  usedw;
    logic        full, empty;

    int nvec = 0;
    int nerr = 0;

    line_fifo_640x16 dut (
        .clock(clock), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .q(q), .usedw(usedw), .full(full), .empty(empty)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic s, input logic w, input logic r, input logic [15:0] d);
        sclr = s; wrreq = w; rdreq = r; data = d;
    endtask

    initial begin
        drive(1'b1, 1'b1, 1'b1, 16'h1111);
        #1;
        // Reset with both requests active
        tick(); tick();
        check("rst_q", q, 16'h0);
        check("rst_usedw", usedw, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        drive(0, 0, 0, 0);

        // Line delay: fill, drop overflow write, drain in order
        for (int i = 0; i < 640; i++) begin
            drive(0, 1, 0, 16'(i));
            tick();
            if (i == 0) begin
                check("fill1_usedw", usedw, 1);
                check("fill1_empty", empty, 0);
            end
        end
        check("fill_usedw", usedw, 640);
        check("fill_full", full, 1);
        drive(0, 1, 0, 16'hFFFF);
        tick();
        check("ovf_usedw", usedw, 640);
        check("ovf_full", full, 1);
        for (int i = 0; i < 640; i++) begin
            drive(0, 0, 1, 0);
            tick();
            check("drain_q", q, 32'(i));
        end
        drive(0, 0, 0, 0);
        check("drain_empty", empty, 1);
        check("drain_usedw", usedw, 0);
        tick();
        check("hold_q", q, 639);

        // Streaming across pointer wrap with 5 words in flight
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 16'(1000 + i));
            tick();
        end
        check("pre_usedw", usedw, 5);
        for (int c = 0; c < 2000; c++) begin
            drive(0, 1, 1, 16'(1005 + c));
            tick();
            check("strm_q", q, 32'(1000 + c));
            check("strm_usedw", usedw, 5);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0);
            tick();
            check("strm_tail_q", q, 32'(3000 + i));
        end
        drive(0, 0, 0, 0);
        check("strm_empty", empty, 1);

        // Underflow: reads on empty are ignored
        drive(0, 1, 0, 16'h1234); tick();
        drive(0, 0, 1, 0); tick();
        check("uf_pre_q", q, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("uf_q", q, 16'h1234);
            check("uf_usedw", usedw, 0);
            check("uf_empty", empty, 1);
        end
        drive(0, 1, 0, 16'hABCD); tick();
        drive(0, 0, 1, 0); tick();
        check("uf_abcd", q, 16'hABCD);
        // No write-through: read with write into empty FIFO is ignored
        drive(0, 1, 1, 16'h7777); tick();
        check("nwt_q", q, 16'hABCD);
        check("nwt_usedw", usedw, 1);
        drive(0, 0, 1, 0); tick();
        check("nwt_read", q, 16'h7777);
        check("nwt_empty", empty, 1);

        // Full with simultaneous read and write
        for (int i = 0; i < 640; i++) begin
            drive(0, 1, 0, 16'(16'h100 + i));
            tick();
        end
        check("f2_full", full, 1);
        drive(0, 1, 1, 16'h5555); tick();
        check("frw_q", q, 16'h100);
        check("frw_usedw", usedw, 640);
        check("frw_full", full, 1);
        for (int i = 1; i < 640; i++) begin
            drive(0, 0, 1, 0);
            tick();
            check("frw_drain_q", q, 32'(16'h100 + i));
        end
        drive(0, 0, 1, 0); tick();
        check("frw_last_q", q, 16'h5555);
        check("frw_empty", empty, 1);
        drive(0, 0, 0, 0);

        // Reset mid-stream beats a concurrent write
        for (int i = 0; i < 300; i++) begin
            drive(0, 1, 0, 16'(i));
            tick();
        end
        check("mid_usedw", usedw, 300);
        drive(1, 1, 0, 16'hDEAD); tick();
        check("mid_rst_usedw", usedw, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_q", q, 0);
        drive(0, 1, 0, 16'h0042); tick();
        check("mid_wr_usedw", usedw, 1);
        drive(0, 0, 1, 0); tick();
        check("mid_rd_q", q, 16'h0042);
        check("mid_rd_empty", empty, 1);
        drive(0, 0, 0, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
